// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared types and constants for the instruction fetch path
// Revision: 1.0
// ============================================================================
package cpu_pkg;

   localparam int unsigned CPU_ADDR_W  = 7;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0;

   typedef struct packed {
      logic [31:0]           instr;
      logic [CPU_ADDR_W-1:0] pc;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : synchronous show-ahead FIFO of fetch entries, flush beats push
// Revision: 1.0
// ============================================================================
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  fetch_entry_t           wdata_i,
   output fetch_entry_t           head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             w_do_pop;
   logic             w_do_push;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign w_do_pop  = pop_i & ~empty_o;
   assign w_do_push = push_i & (~full_o | w_do_pop);

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + (PTR_W+1)'(w_do_push) - (PTR_W+1)'(w_do_pop);
      end
   end

   // Storage carries no reset: an entry is only visible once the count covers it.
   always_ff @(posedge clk) begin
      if (w_do_push && !flush_i && !reset) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// inst_fetch_queue : byte-serial big-endian instruction fetch into a queue for decode
// Revision: 1.0
// ============================================================================
module inst_fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = CPU_ADDR_W,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] PC_START = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_inc
);

   localparam int unsigned       CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

   fetch_state_e      state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [23:0]       asm_q, asm_d;

   logic              w_push;
   logic              w_pop;
   logic              w_space;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;
   fetch_entry_t      w_entry;
   fetch_entry_t      w_head;

   assign mem_addr = fetch_pc_q + ADDR_W'(byte_cnt_q);
   assign w_entry  = '{instr: {asm_q, mem_rdata}, pc: fetch_pc_q};
   assign w_pop    = out_valid & out_ready;
   // A pop on a full queue frees the slot the pending word needs.
   assign w_space  = (w_count < CNT_W'(DEPTH)) | (w_full & w_pop);

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      fetch_pc_d = fetch_pc_q;
      asm_d      = asm_q;
      w_push     = 1'b0;
      if (redirect_valid) begin
         state_d    = FETCH;
         byte_cnt_d = '0;
         fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      end else begin
         case (state_q)
            FETCH: begin
               if (byte_cnt_q != 2'd3) begin
                  case (byte_cnt_q)
                     2'd0:    asm_d[23:16] = mem_rdata;
                     2'd1:    asm_d[15:8]  = mem_rdata;
                     default: asm_d[7:0]   = mem_rdata;
                  endcase
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end else if (w_space) begin
                  w_push     = 1'b1;
                  fetch_pc_d = fetch_pc_q + PC_STEP;
                  byte_cnt_d = '0;
               end else begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (w_space) begin
                  w_push     = 1'b1;
                  fetch_pc_d = fetch_pc_q + PC_STEP;
                  byte_cnt_d = '0;
                  state_d    = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         byte_cnt_q <= '0;
         fetch_pc_q <= PC_START;
         asm_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         fetch_pc_q <= fetch_pc_d;
         asm_q      <= asm_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .flush_i (redirect_valid),
      .wdata_i (w_entry),
      .head_o  (w_head),
      .count_o (w_count),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign out_valid  = ~w_empty;
   assign out_instr  = out_valid ? w_head.instr : NOP_INSTR;
   assign out_pc     = out_valid ? w_head.pc : '0;
   assign out_pc_inc = out_valid ? (w_head.pc + PC_STEP) : '0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch_queue : scoreboard bench for inst_fetch_queue (PC_START 0 and 0x7C)
// Revision: 1.0
// ============================================================================
module tb_inst_fetch_queue;
   import cpu_pkg::*;

   localparam int unsigned AW = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] mem_addr, mem_addr1;
   logic [7:0]    mem_rdata, mem_rdata1;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          out_valid, out_valid1;
   logic          out_ready;
   logic [31:0]   out_instr, out_instr1;
   logic [AW-1:0] out_pc, out_pc1, out_pc_inc, out_pc_inc1;

   int            n_cmp = 0;
   int            n_mis = 0;
   int            n_pop = 0;
   int            pops_before;
   logic          mon_en = 1'b0;
   logic [AW-1:0] sb [$];
   logic [AW-1:0] exp_pc;

   always #5 clk = ~clk;

   // Instruction memory: each byte holds its own address.
   assign mem_rdata  = {1'b0, mem_addr};
   assign mem_rdata1 = {1'b0, mem_addr1};

   inst_fetch_queue #(.ADDR_W(AW), .DEPTH(4), .PC_START(7'h00)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_inc     (out_pc_inc)
   );

   inst_fetch_queue #(.ADDR_W(AW), .DEPTH(4), .PC_START(7'h7C)) dut1 (
      .clk            (clk),
      .reset          (reset),
      .mem_addr       (mem_addr1),
      .mem_rdata      (mem_rdata1),
      .redirect_valid (1'b0),
      .redirect_pc    (7'h00),
      .out_valid      (out_valid1),
      .out_ready      (1'b1),
      .out_instr      (out_instr1),
      .out_pc         (out_pc1),
      .out_pc_inc     (out_pc_inc1)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [AW-1:0] pc);
      logic [AW-1:0] a;
      logic [31:0]   w;
      w = '0;
      for (int i = 0; i < 4; i++) begin
         a = pc + AW'(i);
         w = {w[23:0], 1'b0, a};
      end
      return w;
   endfunction

   task automatic sb_load(input logic [AW-1:0] start);
      sb.delete();
      for (int i = 0; i < 40; i++) sb.push_back(start + AW'(4 * i));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle reset; returns at the start of cycle 0.
   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb_load(7'h00);
   endtask

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (!out_valid) check_eq("nop_when_invalid", out_instr, NOP_INSTR);
         if (out_valid && out_ready) begin
            n_pop++;
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               exp_pc = sb.pop_front();
               check_eq("pop_pc", 32'(out_pc), 32'(exp_pc));
               check_eq("pop_instr", out_instr, exp_word(exp_pc));
               check_eq("pop_pc_inc", 32'(out_pc_inc), 32'(AW'(exp_pc + AW'(4))));
            end
         end
         if (redirect_valid) sb_load({redirect_pc[AW-1:2], 2'b00});
      end
   end

   initial begin
      logic [AW-1:0] a;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sb_load(7'h00);
      mon_en = 1'b1;

      // Power-up latency, first words, and the wrapping PC_START instance
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check_eq("rst_valid", 32'(out_valid), 32'd0);
            check_eq("rst_instr", out_instr, 32'd0);
            check_eq("rst_pc", 32'(out_pc), 32'd0);
            check_eq("rst_pc_inc", 32'(out_pc_inc), 32'd0);
         end
         a = 7'h7C + AW'(c);
         check_eq("t1_addr", 32'(mem_addr), 32'(c));
         check_eq("t1_not_valid", 32'(out_valid), 32'd0);
         check_eq("t5_addr", 32'(mem_addr1), 32'(a));
         tick();
      end
      @(negedge clk);
      check_eq("t1_valid", 32'(out_valid), 32'd1);
      check_eq("t1_instr", out_instr, 32'h00010203);
      check_eq("t1_pc", 32'(out_pc), 32'd0);
      check_eq("t1_pc_inc", 32'(out_pc_inc), 32'd4);
      check_eq("t5_valid", 32'(out_valid1), 32'd1);
      check_eq("t5_instr", out_instr1, 32'h7C7D7E7F);
      check_eq("t5_pc", 32'(out_pc1), 32'h7C);
      check_eq("t5_pc_inc", 32'(out_pc_inc1), 32'h00);
      check_eq("t5_wrap_addr", 32'(mem_addr1), 32'h00);
      tick();
      @(negedge clk);
      check_eq("t1_gap", 32'(out_valid), 32'd0);
      repeat (3) tick();
      @(negedge clk);
      check_eq("t1_second_valid", 32'(out_valid), 32'd1);
      check_eq("t1_second_instr", out_instr, 32'h04050607);
      check_eq("t5_second_pc", 32'(out_pc1), 32'h00);
      check_eq("t5_second_instr", out_instr1, 32'h00010203);
      tick();

      // Back-pressure until full and HOLD, then drain
      out_ready = 1'b0;
      do_reset();
      repeat (40) tick();
      @(negedge clk);
      check_eq("t2_hold_addr", 32'(mem_addr), 32'h13);
      check_eq("t2_full_valid", 32'(out_valid), 32'd1);
      check_eq("t2_head_pc", 32'(out_pc), 32'd0);
      tick();
      check_eq("t2_hold_addr_still", 32'(mem_addr), 32'h13);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("t2_drain_valid", 32'(out_valid), 32'd1);
         check_eq("t2_drain_pc", 32'(out_pc), 32'(4 * i));
         if (i == 1) check_eq("t2_refetch_addr", 32'(mem_addr), 32'h14);
         tick();
      end
      repeat (8) tick();

      // Redirect with two entries queued and byte_cnt=2
      out_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 7'h2B;
      @(negedge clk);
      check_eq("t3_pre_addr", 32'(mem_addr), 32'h0A);
      check_eq("t3_pre_valid", 32'(out_valid), 32'd1);
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) check_eq("t3_flushed", 32'(out_valid), 32'd0);
         check_eq("t3_addr", 32'(mem_addr), 32'(7'h28 + AW'(i)));
         tick();
      end
      @(negedge clk);
      check_eq("t3_valid", 32'(out_valid), 32'd1);
      check_eq("t3_pc", 32'(out_pc), 32'h28);
      repeat (10) tick();

      // Redirect coinciding with a pop
      out_ready = 1'b1;
      do_reset();
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 7'h41;
      pops_before    = n_pop;
      @(negedge clk);
      check_eq("t4_head_valid", 32'(out_valid), 32'd1);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      #1;
      check_eq("t4_empty_after", 32'(out_valid), 32'd0);
      check_eq("t4_pop_count", 32'(n_pop - pops_before), 32'd1);
      repeat (4) tick();
      @(negedge clk);
      check_eq("t4_new_pc", 32'(out_pc), 32'h40);
      repeat (12) tick();

      // Reset for one cycle mid-HOLD with a full queue
      out_ready = 1'b0;
      do_reset();
      repeat (30) tick();
      @(negedge clk);
      check_eq("t6_hold_addr", 32'(mem_addr), 32'h13);
      tick();
      do_reset();
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("t6_valid", 32'(out_valid), 32'd0);
      check_eq("t6_instr", out_instr, 32'd0);
      check_eq("t6_addr", 32'(mem_addr), 32'h00);
      repeat (4) tick();
      @(negedge clk);
      check_eq("t6_restart_pc", 32'(out_pc), 32'h00);
      check_eq("t6_restart_valid", 32'(out_valid), 32'd1);
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
